// File: rtl/mano_isa_pkg.sv
// Shared ISA constants for the 8-bit Mano basic computer control path.
package mano_isa_pkg;

    localparam int ADDR_W = 4;
    localparam int WORD_W = 8;

    // Opcode field, IR[6:4]
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_LDA  = 3'b010;
    localparam logic [2:0] OP_STA  = 3'b011;
    localparam logic [2:0] OP_BUN  = 3'b100;
    localparam logic [2:0] OP_RES5 = 3'b101;
    localparam logic [2:0] OP_RES6 = 3'b110;
    localparam logic [2:0] OP_REG  = 3'b111;

    // Register-reference bit positions inside IR[3:0]
    localparam int B_CLA = 3;
    localparam int B_CMA = 2;
    localparam int B_CIR = 1;
    localparam int B_CIL = 0;

    // AC source select
    localparam logic [1:0] AC_SEL_AND = 2'b00;
    localparam logic [1:0] AC_SEL_ADD = 2'b01;
    localparam logic [1:0] AC_SEL_DR  = 2'b10;

    // Timing-state indices (sequence counter values)
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    typedef struct packed {
        logic       ind;
        logic [2:0] op;
        logic [3:0] addr;
    } instr_t;

    // Opcodes that take an effective address (AND/ADD/LDA/STA/BUN)
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op <= OP_BUN);
    endfunction

endpackage

// File: rtl/ctrl_timing_counter.sv
// Sequence counter: 3-bit count with one-hot T decode.
module ctrl_timing_counter
    import mano_isa_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       SC_CLR,
    input  logic       EN,
    output logic [7:0] T
);

    logic [2:0] sc_q, sc_d;

    // Advance only when enabled; T5 always wraps so an upset count cannot run away.
    always_comb begin
        sc_d = sc_q;
        if (EN) begin
            if (SC_CLR || (sc_q >= T5)) begin
                sc_d = T0;
            end else begin
                sc_d = sc_q + 3'd1;
            end
        end
    end

    // Count register, synchronous reset to T0.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            sc_q <= T0;
        end else begin
            sc_q <= sc_d;
        end
    end

    assign T = 8'd1 << sc_q;

endmodule

// File: rtl/mano_control_unit.sv
// Hardwired control unit for the 8-bit Mano basic computer.
//
//   state | meaning
//   T0    | AR <- PC
//   T1    | IR <- M[AR], PC <- PC + 1
//   T2    | AR <- IR[3:0]
//   T3    | register-reference action / HLT, or indirect AR <- M[AR]
//   T4    | DR <- M[AR] (AND/ADD/LDA), M[AR] <- AC (STA), PC <- AR (BUN)
//   T5    | AC <- f(AC, DR) for AND/ADD/LDA
//
// Strobes are Moore-decoded from (T, IR, HALTED) and qualified so that a
// stalled, halted or resetting cycle never issues anything.
module mano_control_unit
    import mano_isa_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       RUN,
    input  logic [7:0] DATA_IN,
    input  logic [3:0] PC_Q,
    input  logic [3:0] AR_Q,
    output logic [3:0] AR_D,
    output logic       AR_LD,
    output logic [3:0] PC_D,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic       RW,
    output logic       AC_OE,
    output logic       DR_LD,
    output logic       AC_LD,
    output logic [1:0] AC_SEL,
    output logic       AC_CLR,
    output logic       AC_COM,
    output logic       AC_CIR,
    output logic       AC_CIL,
    output logic [7:0] T,
    output logic       HALTED
);

    instr_t     ir_q, ir_d;
    logic       halted_q, halted_d;
    logic [7:0] t;
    logic       en, act, sc_clr;
    logic       is_reg, is_alu;

    assign en     = RUN & ~halted_q;
    assign act    = en & ~CLR;
    assign is_reg = (ir_q.op == OP_REG) & ~ir_q.ind;
    assign is_alu = (ir_q.op == OP_AND) | (ir_q.op == OP_ADD) | (ir_q.op == OP_LDA);

    // Return to T0 at the last state of each instruction class.
    assign sc_clr = (t[T3] & is_reg) | (t[T4] & ~is_alu) | t[T5];

    ctrl_timing_counter u_sc (
        .CLK    (CLK),
        .CLR    (CLR),
        .SC_CLR (sc_clr),
        .EN     (en),
        .T      (t)
    );

    assign T      = t;
    assign HALTED = halted_q;

    // IR captures the fetched word at the end of T1; HLT latches the halt flag at T3.
    always_comb begin
        ir_d     = ir_q;
        halted_d = halted_q;
        if (en && t[T1]) begin
            ir_d = instr_t'(DATA_IN);
        end
        if (en && t[T3] && is_reg && (ir_q.addr == 4'h0)) begin
            halted_d = 1'b1;
        end
    end

    // Instruction register and halt flag.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Strobe decode from the registered state.
    always_comb begin
        AR_D   = 4'h0;
        AR_LD  = 1'b0;
        PC_D   = CLR ? 4'h0 : AR_Q;
        PC_LD  = 1'b0;
        PC_INC = 1'b0;
        RW     = 1'b1;
        AC_OE  = 1'b0;
        DR_LD  = 1'b0;
        AC_LD  = 1'b0;
        AC_SEL = AC_SEL_AND;
        AC_CLR = 1'b0;
        AC_COM = 1'b0;
        AC_CIR = 1'b0;
        AC_CIL = 1'b0;
        if (act) begin
            if (t[T0]) begin
                AR_D  = PC_Q;
                AR_LD = 1'b1;
            end
            if (t[T1]) begin
                PC_INC = 1'b1;
            end
            if (t[T2]) begin
                AR_D  = ir_q.addr;
                AR_LD = 1'b1;
            end
            if (t[T3]) begin
                if (is_reg) begin
                    if (ir_q.addr[B_CLA])      AC_CLR = 1'b1;
                    else if (ir_q.addr[B_CMA]) AC_COM = 1'b1;
                    else if (ir_q.addr[B_CIR]) AC_CIR = 1'b1;
                    else if (ir_q.addr[B_CIL]) AC_CIL = 1'b1;
                end else if (is_mem_op(ir_q.op) && ir_q.ind) begin
                    AR_D  = DATA_IN[3:0];
                    AR_LD = 1'b1;
                end
            end
            if (t[T4]) begin
                case (ir_q.op)
                    OP_AND, OP_ADD, OP_LDA: DR_LD = 1'b1;
                    OP_STA: begin
                        RW    = 1'b0;
                        AC_OE = 1'b1;
                    end
                    OP_BUN:  PC_LD = 1'b1;
                    default: ;
                endcase
            end
            if (t[T5]) begin
                AC_LD = 1'b1;
                case (ir_q.op)
                    OP_AND:  AC_SEL = AC_SEL_AND;
                    OP_ADD:  AC_SEL = AC_SEL_ADD;
                    default: AC_SEL = AC_SEL_DR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mano_control_unit.sv
// Scoreboard bench for mano_control_unit: the stimulus side pushes the
// per-cycle expected control word of each instruction, the monitor pops and
// compares on every cycle that advances.
module tb_mano_control_unit;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       RUN = 1'b0;
    logic [7:0] DATA_IN;
    logic [3:0] PC_Q, AR_Q;
    logic [3:0] AR_D, PC_D;
    logic       AR_LD, PC_LD, PC_INC, RW, AC_OE, DR_LD, AC_LD;
    logic [1:0] AC_SEL;
    logic       AC_CLR, AC_COM, AC_CIR, AC_CIL, HALTED;
    logic [7:0] T;

    always #5 CLK = ~CLK;

    mano_control_unit dut (
        .CLK(CLK), .CLR(CLR), .RUN(RUN), .DATA_IN(DATA_IN),
        .PC_Q(PC_Q), .AR_Q(AR_Q), .AR_D(AR_D), .AR_LD(AR_LD),
        .PC_D(PC_D), .PC_LD(PC_LD), .PC_INC(PC_INC), .RW(RW),
        .AC_OE(AC_OE), .DR_LD(DR_LD), .AC_LD(AC_LD), .AC_SEL(AC_SEL),
        .AC_CLR(AC_CLR), .AC_COM(AC_COM), .AC_CIR(AC_CIR), .AC_CIL(AC_CIL),
        .T(T), .HALTED(HALTED)
    );

    // Minimal datapath: RAM, PC and AR react to the DUT strobes.
    logic [7:0] mem [16];
    logic [3:0] pc_q, ar_q;
    assign PC_Q    = pc_q;
    assign AR_Q    = ar_q;
    assign DATA_IN = mem[ar_q];

    always @(posedge CLK) begin
        if (CLR) begin
            pc_q <= 4'h0;
            ar_q <= 4'h0;
        end else begin
            if (PC_LD)       pc_q <= PC_D;
            else if (PC_INC) pc_q <= pc_q + 4'd1;
            if (AR_LD)       ar_q <= AR_D;
        end
    end

    typedef struct packed {
        logic [7:0] t;
        logic [3:0] ar_d;
        logic       ar_ld;
        logic [3:0] pc_d;
        logic       pc_ld;
        logic       pc_inc;
        logic       rw;
        logic       ac_oe;
        logic       dr_ld;
        logic       ac_ld;
        logic [1:0] ac_sel;
        logic       ac_clr;
        logic       ac_com;
        logic       ac_cir;
        logic       ac_cil;
        logic       halted;
    } obs_t;

    obs_t       q[$];
    int         checks = 0;
    int         passed = 0;
    logic [3:0] m_pc = 4'h0;

    function automatic obs_t idle(input logic [7:0] t, input logic h);
        obs_t o;
        o        = '0;
        o.t      = t;
        o.rw     = 1'b1;
        o.halted = h;
        return o;
    endfunction

    // Value fields only matter alongside their strobe.
    function automatic obs_t norm(input obs_t o);
        obs_t r;
        r = o;
        if (!r.ar_ld) r.ar_d   = 4'h0;
        if (!r.pc_ld) r.pc_d   = 4'h0;
        if (!r.ac_ld) r.ac_sel = 2'b00;
        return r;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s @%0t got=%h required=%h", name, $time, got, exp);
    endtask

    // Monitor: every cycle either a reset cycle, a stall, or one popped step.
    always @(negedge CLK) begin : monitor
        obs_t g, e;
        static logic clr_prev = 1'b0;
        g = '{t:T, ar_d:AR_D, ar_ld:AR_LD, pc_d:PC_D, pc_ld:PC_LD, pc_inc:PC_INC,
              rw:RW, ac_oe:AC_OE, dr_ld:DR_LD, ac_ld:AC_LD, ac_sel:AC_SEL,
              ac_clr:AC_CLR, ac_com:AC_COM, ac_cir:AC_CIR, ac_cil:AC_CIL, halted:HALTED};
        if (CLR) begin
            e = idle(8'h01, 1'b0);
            if (clr_prev) begin
                check("reset_state", norm(g), e);
            end else begin
                g.t      = 8'h01;
                g.halted = 1'b0;
                check("clr_no_strobe", norm(g), e);
            end
        end else if (q.size() > 0) begin
            if (RUN) begin
                e = q.pop_front();
                check("step", norm(g), e);
            end else begin
                e = idle(q[0].t, q[0].halted);
                check("stall_hold", norm(g), e);
            end
        end
        clr_prev = CLR;
    end

    // Reference model: expected control words of one instruction, from the ISA rules.
    task automatic issue(input logic [7:0] ins, output int n);
        logic       ind;
        logic [2:0] op;
        logic [3:0] a, eff;
        obs_t       e;
        ind = ins[7];
        op  = ins[6:4];
        a   = ins[3:0];
        eff = a;
        e = idle(8'h01, 1'b0); e.ar_ld = 1'b1; e.ar_d = m_pc; q.push_back(e);
        e = idle(8'h02, 1'b0); e.pc_inc = 1'b1;               q.push_back(e);
        e = idle(8'h04, 1'b0); e.ar_ld = 1'b1; e.ar_d = a;    q.push_back(e);
        e = idle(8'h08, 1'b0);
        if (op == 3'd7 && !ind) begin
            if (a >= 4'd8)      e.ac_clr = 1'b1;
            else if (a >= 4'd4) e.ac_com = 1'b1;
            else if (a >= 4'd2) e.ac_cir = 1'b1;
            else if (a == 4'd1) e.ac_cil = 1'b1;
            q.push_back(e);
            n    = 4;
            m_pc = m_pc + 4'd1;
            return;
        end
        if (op <= 3'd4 && ind) begin
            eff     = mem[a][3:0];
            e.ar_ld = 1'b1;
            e.ar_d  = eff;
        end
        q.push_back(e);
        e = idle(8'h10, 1'b0);
        case (op)
            3'd0, 3'd1, 3'd2: e.dr_ld = 1'b1;
            3'd3: begin e.rw = 1'b0; e.ac_oe = 1'b1; end
            3'd4: begin e.pc_ld = 1'b1; e.pc_d = eff; end
            default: ;
        endcase
        q.push_back(e);
        n = 5;
        if (op <= 3'd2) begin
            e = idle(8'h20, 1'b0);
            e.ac_ld  = 1'b1;
            e.ac_sel = (op == 3'd0) ? 2'b00 : (op == 3'd1) ? 2'b01 : 2'b10;
            q.push_back(e);
            n = 6;
        end
        m_pc = (op == 3'd4) ? eff : m_pc + 4'd1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clr();
        q.delete();
        CLR = 1'b1;
        RUN = 1'($urandom_range(0, 1));
        tick();
        tick();
        CLR  = 1'b0;
        RUN  = 1'b0;
        m_pc = 4'h0;
    endtask

    task automatic run(input logic [7:0] ins, input bit rnd_mem, input int stall_at,
                       input int stall_len, input int abort_at, input bit rnd_stall);
        int n, done, stalled, guard;
        if (rnd_mem)
            for (int k = 0; k < 16; k++)
                if (4'(k) != m_pc) mem[k] = 8'($urandom);
        mem[m_pc] = ins;
        issue(ins, n);
        done    = 0;
        stalled = 0;
        guard   = 0;
        while (done < n && guard < 1000) begin
            guard++;
            if (done == abort_at) begin
                do_clr();
                return;
            end
            if (done == stall_at && stalled < stall_len) begin
                RUN = 1'b0;
                stalled++;
            end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
                RUN = 1'b0;
            end else begin
                RUN = 1'b1;
            end
            tick();
            if (RUN) done++;
        end
        if (done < n) begin
            checks++;
            $display("FAIL run_bound ins=%h done=%0d required=%0d", ins, done, n);
        end
    endtask

    task automatic run_halt();
        run(8'h70, 1'b0, -1, 0, -1, 1'b0);
        for (int k = 0; k < 20; k++) q.push_back(idle(8'h01, 1'b1));
        RUN = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        do_clr();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout, bench did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
        do_clr();

        mem[4'hA] = 8'h5C;
        run(8'h2A, 1'b0, -1, 0, -1, 1'b0);   // LDA 0xA from PC 0
        mem[4'hC] = 8'h07;
        run(8'h9C, 1'b0, -1, 0, -1, 1'b0);   // ADD indirect via 0xC
        run(8'h35, 1'b0, -1, 0, -1, 1'b0);   // STA
        run(8'h43, 1'b0, -1, 0, -1, 1'b0);   // BUN 0x3
        run(8'h50, 1'b0, -1, 0, -1, 1'b0);   // reserved
        run(8'h7C, 1'b0, -1, 0, -1, 1'b0);   // CLA wins over CMA
        run(8'h2A, 1'b0, 4, 3, -1, 1'b0);    // LDA, 3-cycle stall in T4
        run_halt();
        run(8'h1C, 1'b0, -1, 0, 3, 1'b0);    // ADD aborted by CLR at T3

        for (int k = 0; k < 90; k++) begin
            logic [7:0] ins;
            int         ab;
            ins = 8'($urandom);
            if (ins[6:4] == 3'd5 || ins[6:4] == 3'd6) ins[7] = 1'b0;
            if (ins == 8'h70) ins = 8'h71;
            ab = -1;
            if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(0, 3));
            run(ins, 1'b1, -1, 0, ab, 1'b1);
            if (k == 45) run_halt();
        end

        RUN = 1'b0;
        tick();
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL queue_drain left=%0d required=0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mano_control_unit.md
# mano_control_unit

Hardwired control unit for the 8-bit Mano basic computer (4-bit address, 8-bit word). Owns the instruction register and the T0–T5 timing sequence, decodes each fetched instruction, and drives every load/increment/clear strobe of PC, AR, DR and AC plus the RAM read/write line. Sits directly upstream of those registers and the RAM, and replaces the ad-hoc control sequencing currently hand-driven on the datapath.

## Interface
- Parameters: none. Widths are fixed: address 4, word 8.
- `CLK  in  1`  system clock, all state updates on rising edge.
- `CLR  in  1`  reset, synchronous, active-high.
- `RUN  in  1`  advance enable. 0 = stall: state held, all strobes 0.
- `DATA_IN  in  8`  RAM read data, valid combinationally for the current AR.
- `PC_Q  in  4`  program counter value.
- `AR_Q  in  4`  address register value.
- `AR_D  out  4`  AR load value.
- `AR_LD  out  1`  AR load strobe.
- `PC_D  out  4`  PC load value, equal to AR_Q.
- `PC_LD, PC_INC  out  1 each`  PC load and increment strobes.
- `RW  out  1`  RAM direction, 1 = read, 0 = write.
- `AC_OE  out  1`  drive AC onto the RAM data bus (STA).
- `DR_LD  out  1`  DR load from DATA_IN.
- `AC_LD  out  1`  AC load strobe.
- `AC_SEL  out  2`  AC source: 00 = AC&DR, 01 = AC+DR, 10 = DR.
- `AC_CLR, AC_COM, AC_CIR, AC_CIL  out  1 each`  register-reference strobes.
- `T  out  8`  one-hot timing, bit k = Tk.
- `HALTED  out  1`  set by HLT.

## Operation
- Instruction format: bit 7 = I, bits 6:4 = opcode, bits 3:0 = address or B.
- Opcodes: 000 AND, 001 ADD, 010 LDA, 011 STA, 100 BUN, 101 and 110 reserved, 111 with I=0 is register-reference, 111 with I=1 is reserved.
- All strobes are Moore-decoded from the registered (T, IR, HALTED) state and qualified by RUN & ~HALTED.
- T0: AR_D = PC_Q, AR_LD.
- T1: RW = 1; IR <= DATA_IN at the end of T1; PC_INC.
- T2: AR_D = IR[3:0], AR_LD.
- T3, register-reference: exactly one action, priority B3 CLA (AC_CLR) > B2 CMA (AC_COM) > B1 CIR > B0 CIL. B = 0000 is HLT and sets HALTED. Next state is T0.
- T3, memory-reference with I=1: AR_D = DATA_IN[3:0], AR_LD.
- T3, memory-reference with I=0: no strobes.
- T4, AND/ADD/LDA: RW = 1, DR_LD.
- T4, STA: RW = 0, AC_OE; next state is T0.
- T4, BUN: PC_LD; next state is T0.
- T4, reserved opcode: no strobes; next state is T0.
- T5, AND/ADD/LDA: AC_LD with AC_SEL = 00, 01 or 10 respectively; next state is T0.
- RW is 1 in every state except STA T4.

## Timing
- Reset: T = 0x01, IR = 0x00, HALTED = 0, RW = 1, every other output 0 while CLR = 1. CLR mid-instruction aborts it: T0 on the next cycle, and no strobe is issued in the cycle CLR is high.
- Cycles per instruction with RUN held high: register-reference 4; STA, BUN and reserved 5; AND, ADD and LDA 6.
- With RUN = 0 in any state, T, IR and HALTED are held. The pending state's strobes appear in the first cycle RUN = 1 again. No strobe is ever issued twice.
- HALTED is set at the end of HLT's T3. After that, T stays 0x01, all strobes stay 0, and RUN is ignored. Only CLR exits halt.
- The PC wraps 0xF to 0x0 in the PC register itself; this block issues PC_INC regardless of value.
- IR is visible to decode from T2 onward. A DATA_IN change after T1 does not affect the current instruction, except for the indirect address at T3 and the DR load at T4.

## Structure
- Shared package `mano_isa_pkg`:
  - opcode constants OP_AND through OP_REG;
  - B bit positions B_CLA, B_CMA, B_CIR, B_CIL;
  - AC_SEL encodings;
  - T-state indices.
- Sub-module `ctrl_timing_counter`: 3-bit counter with one-hot decode. Inputs: CLK, CLR (reset), SC_CLR (return to T0), EN (RUN & ~HALTED). Output: T[7:0].
- Top level: IR register, HALTED flag, decode logic.

## Test plan
- Reset, then RUN = 1 with mem[PC = 0] = 0x2A (LDA 0xA) and mem[0xA] = 0x5C. Required: T walks 01→02→04→08→10→20→01; AR_D = 0x0 at T0; PC_INC at T1; AR_D = 0xA at T2; DR_LD at T4; AC_LD with AC_SEL = 10 at T5.
- ADD indirect 0x9C with mem[0xC] = 0x07. Required: T3 AR_LD with AR_D = 0x7; T4 DR_LD; T5 AC_SEL = 01; 6 cycles total.
- STA 0x35. Required: T4 RW = 0 and AC_OE = 1 for exactly 1 cycle; RW = 1 in every other cycle; next fetch starts 5 cycles after the first T0.
- BUN 0x43 with AR_Q = 0x3. Required: T4 PC_LD with PC_D = 0x3. Reserved 0x50: no strobes at T3 or T4; back to T0 after 5 cycles.
- Register-reference:
  - 0x7C (CLA and CMA both set): only AC_CLR at T3.
  - 0x70: HALTED = 1 from the next cycle; all strobes stay 0 for 20 cycles with RUN = 1.
  - CLR clears HALTED.
- RUN = 0 for 3 cycles while in T4 of LDA. Required: T = 0x10 held, no DR_LD. Then DR_LD fires once when RUN = 1. A separate run with CLR asserted during T3 of ADD must give T0 next, with no AC_LD.
